// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with a destination scoreboard.
//
// Two combinational read ports, two write ports (B has priority over A on an
// address collision), and a per-register busy bit set by a reservation and
// cleared by a write.  Optional hard-wired zero register and optional
// same-cycle write-to-read forwarding for both data and busy status.
//
// Ports:
//   clk                  rising-edge clock for all state
//   rst                  asynchronous active-high reset (reg[i] = i, busy = 0)
//   rd1_addr/rd2_addr    read addresses
//   rd1_data/rd2_data    read data (combinational)
//   rd1_busy/rd2_busy    busy bit of the addressed register (combinational)
//   wa_en/wa_addr/wa_data  write port A
//   wb_en/wb_addr/wb_data  write port B (wins over A on the same address)
//   res_en/res_addr      reserve a destination (sets its busy bit)
//   any_busy             OR of all registered busy bits
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              any_busy
);

  localparam int              NREGS     = 2 ** ADDR_W;
  localparam logic            ZERO_HW   = (ZERO_REG != 0);
  localparam logic            BYPASS_EN = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // Effective enables: nothing commits or forwards while reset is held, and
  // register 0 is untouchable when it is hard-wired.
  logic wa_act;
  logic wb_act;
  logic res_act;
  assign wa_act  = wa_en  & ~rst & ~(ZERO_HW & (wa_addr  == ADDR_ZERO));
  assign wb_act  = wb_en  & ~rst & ~(ZERO_HW & (wb_addr  == ADDR_ZERO));
  assign res_act = res_en & ~rst & ~(ZERO_HW & (res_addr == ADDR_ZERO));

  // Per-read-port hit detection against the in-flight writes and reservation.
  logic wa_hit1, wb_hit1, res_hit1;
  logic wa_hit2, wb_hit2, res_hit2;
  assign wa_hit1  = wa_act  & (wa_addr  == rd1_addr);
  assign wb_hit1  = wb_act  & (wb_addr  == rd1_addr);
  assign res_hit1 = res_act & (res_addr == rd1_addr);
  assign wa_hit2  = wa_act  & (wa_addr  == rd2_addr);
  assign wb_hit2  = wb_act  & (wb_addr  == rd2_addr);
  assign res_hit2 = res_act & (res_addr == rd2_addr);

  // Next-state array and scoreboard: B overrides A, reservation overrides clear.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wb_act && (wb_addr == ADDR_W'(i))) ? wb_data :
                  (wa_act && (wa_addr == ADDR_W'(i))) ? wa_data : regs_q[i];
      busy_d[i] = (res_act && (res_addr == ADDR_W'(i))) ? 1'b1 :
                  ((wa_act && (wa_addr == ADDR_W'(i))) ||
                   (wb_act && (wb_addr == ADDR_W'(i)))) ? 1'b0 : busy_q[i];
    end
  end

  // State registers; reset loads each register with its own index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      busy_q <= {NREGS{1'b0}};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Read port 1 data, optionally forwarding the write of this cycle.
  always_comb begin
    if (BYPASS_EN && wb_hit1) begin
      rd1_data = wb_data;
    end else if (BYPASS_EN && wa_hit1) begin
      rd1_data = wa_data;
    end else begin
      rd1_data = regs_q[rd1_addr];
    end
  end

  // Read port 2 data, optionally forwarding the write of this cycle.
  always_comb begin
    if (BYPASS_EN && wb_hit2) begin
      rd2_data = wb_data;
    end else if (BYPASS_EN && wa_hit2) begin
      rd2_data = wa_data;
    end else begin
      rd2_data = regs_q[rd2_addr];
    end
  end

  // Busy status: a same-cycle clearing write hides the busy bit unless the
  // same address is being re-reserved in that cycle.
  always_comb begin
    if (BYPASS_EN && (wa_hit1 || wb_hit1) && !res_hit1) begin
      rd1_busy = 1'b0;
    end else begin
      rd1_busy = busy_q[rd1_addr];
    end
    if (BYPASS_EN && (wa_hit2 || wb_hit2) && !res_hit2) begin
      rd2_busy = 1'b0;
    end else begin
      rd2_busy = busy_q[rd2_addr];
    end
  end

  assign any_busy = |busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed testbench for register_file_mp.  Two instances share all inputs:
// dut (BYPASS=1) and dut_nb (BYPASS=0).  Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well clear of the rising edge.
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  rd1_addr, rd2_addr;
  logic [31:0] rd1_data, rd2_data;
  logic        rd1_busy, rd2_busy;
  logic        wa_en, wb_en, res_en;
  logic [4:0]  wa_addr, wb_addr, res_addr;
  logic [31:0] wa_data, wb_data;
  logic        any_busy;
  logic [31:0] nb_rd1_data, nb_rd2_data;
  logic        nb_rd1_busy, nb_rd2_busy, nb_any_busy;

  int checks;
  int failures;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .res_en(res_en), .res_addr(res_addr),
    .any_busy(any_busy)
  );

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(nb_rd1_data), .rd2_data(nb_rd2_data),
    .rd1_busy(nb_rd1_busy), .rd2_busy(nb_rd2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .res_en(res_en), .res_addr(res_addr),
    .any_busy(nb_any_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    wa_en = 1'b0; wa_addr = 5'd0; wa_data = 32'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    res_en = 1'b0; res_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    rd1_addr = 5'd6; rd2_addr = 5'd31;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (rd1_data !== 32'd6) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd1_data, 32'd6); end
    checks++; if (rd2_data !== 32'd31) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", rd2_data, 32'd31); end
    checks++; if (any_busy !== 1'b0) begin failures++; $display("FAIL reset_any_busy got=%b exp=0", any_busy); end
    checks++; if (rd1_busy !== 1'b0 || rd2_busy !== 1'b0) begin failures++; $display("FAIL reset_rd_busy got=%b%b exp=00", rd1_busy, rd2_busy); end
    rst = 1'b0;
    #1;
    checks++; if (nb_rd2_data !== 32'd31) begin failures++; $display("FAIL reset_nb_rd2 got=%h exp=%h", nb_rd2_data, 32'd31); end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEADBEEF; rd1_addr = 5'd3;
    #1;
    checks++; if (rd1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_bypass got=%h exp=%h", rd1_data, 32'hDEADBEEF); end
    checks++; if (nb_rd1_data !== 32'd3) begin failures++; $display("FAIL wr_nobypass got=%h exp=%h", nb_rd1_data, 32'd3); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_commit got=%h exp=%h", rd1_data, 32'hDEADBEEF); end
    checks++; if (nb_rd1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_commit_nb got=%h exp=%h", nb_rd1_data, 32'hDEADBEEF); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
    rd1_addr = 5'd7;
    #1;
    checks++; if (rd1_data !== 32'h22) begin failures++; $display("FAIL dual_fwd got=%h exp=%h", rd1_data, 32'h22); end
    checks++; if (nb_rd1_data !== 32'd7) begin failures++; $display("FAIL dual_nb got=%h exp=%h", nb_rd1_data, 32'd7); end
    @(negedge clk);
    // Distinct addresses on both ports in one cycle.
    wa_addr = 5'd10; wa_data = 32'h0000_000A;
    wb_addr = 5'd11; wb_data = 32'h0000_000B;
    rd2_addr = 5'd10;
    #1;
    checks++; if (rd1_data !== 32'h22) begin failures++; $display("FAIL dual_commit got=%h exp=%h", rd1_data, 32'h22); end
    checks++; if (rd2_data !== 32'h0000_000A) begin failures++; $display("FAIL split_fwd_a got=%h exp=%h", rd2_data, 32'h0000_000A); end
    @(negedge clk);
    idle_inputs();
    rd1_addr = 5'd11;
    #1;
    checks++; if (nb_rd1_data !== 32'h0000_000B) begin failures++; $display("FAIL split_b got=%h exp=%h", nb_rd1_data, 32'h0000_000B); end
    checks++; if (nb_rd2_data !== 32'h0000_000A) begin failures++; $display("FAIL split_a got=%h exp=%h", nb_rd2_data, 32'h0000_000A); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    res_en = 1'b1; res_addr = 5'd0;
    rd1_addr = 5'd0;
    #1;
    checks++; if (rd1_data !== 32'd0) begin failures++; $display("FAIL zero_in_cycle got=%h exp=0", rd1_data); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd1_data !== 32'd0) begin failures++; $display("FAIL zero_after got=%h exp=0", rd1_data); end
    checks++; if (rd1_busy !== 1'b0 || any_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b%b exp=00", rd1_busy, any_busy); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    res_en = 1'b1; res_addr = 5'd5; rd2_addr = 5'd5;
    #1;
    checks++; if (rd2_busy !== 1'b0) begin failures++; $display("FAIL res_not_yet got=%b exp=0", rd2_busy); end
    @(negedge clk);
    res_en = 1'b0;
    #1;
    checks++; if (rd2_busy !== 1'b1 || any_busy !== 1'b1) begin failures++; $display("FAIL res_set got=%b%b exp=11", rd2_busy, any_busy); end
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h55;
    res_en = 1'b1; res_addr = 5'd5;
    #1;
    checks++; if (rd2_busy !== 1'b1) begin failures++; $display("FAIL res_wr_same_cycle got=%b exp=1", rd2_busy); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd2_busy !== 1'b1 || any_busy !== 1'b1) begin failures++; $display("FAIL set_wins got=%b%b exp=11", rd2_busy, any_busy); end
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h66;
    #1;
    checks++; if (rd2_busy !== 1'b0) begin failures++; $display("FAIL clr_bypass got=%b exp=0", rd2_busy); end
    checks++; if (nb_rd2_busy !== 1'b1) begin failures++; $display("FAIL clr_nobypass got=%b exp=1", nb_rd2_busy); end
    checks++; if (any_busy !== 1'b1) begin failures++; $display("FAIL any_no_bypass got=%b exp=1", any_busy); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (any_busy !== 1'b0 || rd2_busy !== 1'b0) begin failures++; $display("FAIL clr_done got=%b%b exp=00", any_busy, rd2_busy); end
    // Port B also clears a reservation.
    @(negedge clk);
    res_en = 1'b1; res_addr = 5'd12; rd1_addr = 5'd12;
    @(negedge clk);
    idle_inputs();
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h1212;
    #1;
    checks++; if (nb_rd1_busy !== 1'b1 || rd1_busy !== 1'b0) begin failures++; $display("FAIL wb_clr_cycle got=%b%b exp=10", nb_rd1_busy, rd1_busy); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (nb_any_busy !== 1'b0) begin failures++; $display("FAIL wb_clr_done got=%b exp=0", nb_any_busy); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h0000ABCD;
    res_en = 1'b1; res_addr = 5'd9;
    rd1_addr = 5'd9; rd2_addr = 5'd3;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd1_data !== 32'h0000ABCD || rd1_busy !== 1'b1) begin failures++; $display("FAIL pre_rst got=%h/%b exp=0000abcd/1", rd1_data, rd1_busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rd1_data !== 32'd9) begin failures++; $display("FAIL async_rst_data got=%h exp=%h", rd1_data, 32'd9); end
    checks++; if (rd1_busy !== 1'b0 || any_busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b%b exp=00", rd1_busy, any_busy); end
    checks++; if (rd2_data !== 32'd3) begin failures++; $display("FAIL async_rst_reg3 got=%h exp=%h", rd2_data, 32'd3); end
    // Writes and reserves under reset are discarded, including forwarding.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h77;
    res_en = 1'b1; res_addr = 5'd9;
    #1;
    checks++; if (rd1_data !== 32'd9) begin failures++; $display("FAIL rst_no_fwd got=%h exp=%h", rd1_data, 32'd9); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++; if (rd1_data !== 32'd9 || nb_any_busy !== 1'b0) begin failures++; $display("FAIL rst_discard got=%h/%b exp=00000009/0", rd1_data, nb_any_busy); end
    // First edge after release is live.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h99;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (nb_rd1_data !== 32'h99) begin failures++; $display("FAIL post_rst_write got=%h exp=%h", nb_rd1_data, 32'h99); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rd1_addr = 5'd0;
    rd2_addr = 5'd0;
    idle_inputs();
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
